cv_weights_loader: RTL and testbench

//  Write side of the weights buffer: accepts a narrow valid/ready weight stream from the
//  DMA/host path, packs IN_W-bit beats into ROW_W-bit rows and writes them to the weights

---
 rtl/cv_weights_loader.sv | 197 +++++++++++++++++++
 tb/tb_cv_weights_loader.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cv_weights_loader.sv
// ----------------------------------------------------------------------------
// cv_weights_loader
// Write side of the weights buffer. It accepts a narrow valid/ready weight
// stream, packs IN_W-bit beats into ROW_W-bit rows (first beat into the least
// significant slice), and writes each completed row to the buffer write port.
// Rows go to sequential addresses starting at 0. The load must finish before
// conv read-out begins, because read-out walks the buffer from address 0 up.
//
// Optional feature: define WEIGHTS_CHECKSUM_EN to build a 32-bit byte-sum of
// every accepted beat. Without the macro, o_checksum is tied to zero.
//
// Ports
//   i_clk        clock
//   i_rst_n      asynchronous active-low reset
//   i_start      1-cycle pulse: begin a load of i_num_rows rows (IDLE only)
//   i_num_rows   rows to load, 0..2^ADR_W (larger values are clamped)
//   i_s_data     stream beat; the first beat of a row is row bits [IN_W-1:0]
//   i_s_valid    stream beat valid
//   o_s_ready    loader accepts a beat (high only while loading)
//   o_wr_en      buffer write enable, one cycle per row
//   o_wr_adr     buffer write address (holds between writes)
//   o_wr_data    buffer write data (holds between writes)
//   o_busy       load in progress, through the cycle o_done is high
//   o_done       1-cycle pulse once all rows are written
//   o_checksum   byte-sum of the loaded weights, valid at o_done
// ----------------------------------------------------------------------------
module cv_weights_loader #(
    parameter int IN_W           = 64,
    parameter int WEIGHTS_IN_ROW = 64,
    parameter int ROW_W          = WEIGHTS_IN_ROW * 8,
    parameter int ADR_W          = 11
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_start,
    input  logic [ADR_W:0]     i_num_rows,
    input  logic [IN_W-1:0]    i_s_data,
    input  logic               i_s_valid,
    output logic               o_s_ready,
    output logic               o_wr_en,
    output logic [ADR_W-1:0]   o_wr_adr,
    output logic [ROW_W-1:0]   o_wr_data,
    output logic               o_busy,
    output logic               o_done,
    output logic [31:0]        o_checksum
);

    localparam int BEATS  = ROW_W / IN_W;
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);
    localparam logic [ADR_W:0]    ROWS_MAX  = {1'b1, {ADR_W{1'b0}}};

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_FIN  = 2'd2;

    logic [1:0]        r_state;
    logic              r_s_ready;
    logic              r_wr_en;
    logic [ADR_W-1:0]  r_wr_adr;
    logic [ROW_W-1:0]  r_wr_data;
    logic              r_busy;
    logic              r_done;
    logic [BEAT_W-1:0] r_beat_cnt;
    logic [ADR_W:0]    r_row_cnt;
    logic [ADR_W:0]    r_num_rows;
    logic [ROW_W-1:0]  r_row_buf;

    logic [1:0]        w_state_nxt;
    logic              w_start_acc;
    logic              w_beat_acc;
    logic              w_last_beat;
    logic              w_last_row;
    logic [ADR_W:0]    w_num_clamped;
    logic [ADR_W:0]    w_row_cnt_inc;
    logic [ROW_W-1:0]  w_row_full;

    // start only counts in IDLE; beats only while o_s_ready is high (LOAD),
    // so the two can never coincide
    assign w_start_acc   = i_start && (r_state == ST_IDLE);
    assign w_beat_acc    = i_s_valid && r_s_ready;
    assign w_last_beat   = w_beat_acc && (r_beat_cnt == LAST_BEAT);
    assign w_row_cnt_inc = r_row_cnt + (ADR_W + 1)'(1);
    assign w_last_row    = (w_row_cnt_inc == r_num_rows);
    assign w_num_clamped = (i_num_rows > ROWS_MAX) ? ROWS_MAX : i_num_rows;

    // Row image including the beat being accepted this cycle, so the final
    // beat of a row can be written out without an extra packing cycle
    always_comb begin
        w_row_full = r_row_buf;
        w_row_full[r_beat_cnt * IN_W +: IN_W] = i_s_data;
    end

    // Next-state decode for the load sequencer
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_start_acc && (w_num_clamped != '0)) begin
                    w_state_nxt = ST_LOAD;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (w_last_beat && w_last_row) begin
                    w_state_nxt = ST_FIN;
                end else begin
                    w_state_nxt = ST_LOAD;
                end
            end
            ST_FIN:  w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Sequencer state, beat packing, row writes and status outputs
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= ST_IDLE;
            r_s_ready  <= 1'b0;
            r_wr_en    <= 1'b0;
            r_wr_adr   <= '0;
            r_wr_data  <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_beat_cnt <= '0;
            r_row_cnt  <= '0;
            r_num_rows <= '0;
            r_row_buf  <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_s_ready <= (w_state_nxt == ST_LOAD);
            // busy stays up through FIN and the following done cycle
            r_busy    <= (w_state_nxt != ST_IDLE) || (r_state == ST_FIN);
            // done follows FIN, or directly follows a zero-row start
            r_done    <= (r_state == ST_FIN) || (w_start_acc && (w_num_clamped == '0));
            r_wr_en   <= w_last_beat;

            if (w_start_acc) begin
                r_num_rows <= w_num_clamped;
                r_row_cnt  <= '0;
                r_beat_cnt <= '0;
            end else if (w_beat_acc) begin
                r_row_buf <= w_row_full;
                if (w_last_beat) begin
                    r_beat_cnt <= '0;
                    r_row_cnt  <= w_row_cnt_inc;
                end else begin
                    r_beat_cnt <= r_beat_cnt + BEAT_W'(1);
                end
            end

            if (w_last_beat) begin
                r_wr_adr  <= r_row_cnt[ADR_W-1:0];
                r_wr_data <= w_row_full;
            end
        end
    end

    assign o_s_ready = r_s_ready;
    assign o_wr_en   = r_wr_en;
    assign o_wr_adr  = r_wr_adr;
    assign o_wr_data = r_wr_data;
    assign o_busy    = r_busy;
    assign o_done    = r_done;

`ifdef WEIGHTS_CHECKSUM_EN
    // Unsigned sum of all bytes in one beat
    function automatic logic [31:0] beat_byte_sum(input logic [IN_W-1:0] d);
        logic [31:0] s;
        s = 32'd0;
        for (int i = 0; i < IN_W / 8; i++) begin
            s = s + {24'd0, d[i*8 +: 8]};
        end
        return s;
    endfunction

    logic [31:0] r_checksum;

    // Running byte-sum, cleared on every accepted start, held otherwise
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_checksum <= 32'd0;
        end else if (w_start_acc) begin
            r_checksum <= 32'd0;
        end else if (w_beat_acc) begin
            r_checksum <= r_checksum + beat_byte_sum(i_s_data);
        end
    end

    assign o_checksum = r_checksum;
`else
    assign o_checksum = 32'd0;
`endif

endmodule

// File: tb/tb_cv_weights_loader.sv
module tb_cv_weights_loader;

    localparam int IN_W  = 64;
    localparam int ROW_W = 512;
    localparam int ADR_W = 11;
    localparam int BEATS = ROW_W / IN_W;

`ifdef WEIGHTS_CHECKSUM_EN
    localparam bit CKS_EN = 1'b1;
`else
    localparam bit CKS_EN = 1'b0;
`endif

    typedef logic [ROW_W-1:0] w_t;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic [ADR_W:0]    num_rows;
    logic [IN_W-1:0]   s_data;
    logic              s_valid;
    logic              s_ready;
    logic              wr_en;
    logic [ADR_W-1:0]  wr_adr;
    logic [ROW_W-1:0]  wr_data;
    logic              busy;
    logic              done;
    logic [31:0]       checksum;

    int n_checks = 0;
    int n_errors = 0;

    logic [IN_W-1:0]  beat_q[$];
    logic [ADR_W-1:0] got_adr[$];
    logic [ROW_W-1:0] got_data[$];
    int               done_cnt = 0;
    int               got_base;
    int               done_base;
    logic [31:0]      cks_at_done;

    cv_weights_loader dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_start    (start),
        .i_num_rows (num_rows),
        .i_s_data   (s_data),
        .i_s_valid  (s_valid),
        .o_s_ready  (s_ready),
        .o_wr_en    (wr_en),
        .o_wr_adr   (wr_adr),
        .o_wr_data  (wr_data),
        .o_busy     (busy),
        .o_done     (done),
        .o_checksum (checksum)
    );

    always #5 clk = ~clk;

    // write/done monitor, sampled away from the active edge
    always @(negedge clk) begin
        if (wr_en) begin
            got_adr.push_back(wr_adr);
            got_data.push_back(wr_data);
        end
        if (done) done_cnt++;
    end

    task automatic chk(input string tag, input w_t obs, input w_t exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // reference: row r is beats r*BEATS .. r*BEATS+BEATS-1, first beat lowest
    function automatic w_t model_row(input int r);
        w_t row;
        row = '0;
        for (int k = 0; k < BEATS; k++) row[k*IN_W +: IN_W] = beat_q[r*BEATS + k];
        return row;
    endfunction

    function automatic logic [31:0] model_sum();
        int unsigned s;
        s = 0;
        foreach (beat_q[i]) for (int j = 0; j < IN_W / 8; j++) s += beat_q[i][j*8 +: 8];
        return CKS_EN ? s : 32'd0;
    endfunction

    task automatic pulse_start(input int n);
        start    = 1'b1;
        num_rows = (ADR_W + 1)'(n);
        tick();
        start    = 1'b0;
    endtask

    // mode 0 random, 1 ascending byte pattern, 2 all 8'hFF
    task automatic send_beats(input int n, input int gap_pct, input int mode);
        int wait_cnt;
        logic [IN_W-1:0] d;
        for (int b = 0; b < n; b++) begin
            while ($urandom_range(0, 99) < gap_pct) begin
                s_valid = 1'b0;
                tick();
            end
            if (mode == 1) begin
                for (int j = 0; j < 8; j++) d[j*8 +: 8] = 8'((beat_q.size() % BEATS) * 8 + j);
            end else if (mode == 2) begin
                d = 64'hFFFF_FFFF_FFFF_FFFF;
            end else begin
                d = {$urandom(), $urandom()};
            end
            s_valid  = 1'b1;
            s_data   = d;
            wait_cnt = 0;
            while (!s_ready && wait_cnt < 50) begin
                tick();
                wait_cnt++;
            end
            if (!s_ready) begin
                chk("ready_timeout", w_t'(s_ready), w_t'(1));
                s_valid = 1'b0;
                return;
            end
            beat_q.push_back(d);
            tick();
            s_valid = 1'b0;
            if (beat_q.size() % BEATS == 0) begin
                chk("wr_en_latency", w_t'(wr_en), w_t'(1));
                chk("wr_adr_now", w_t'(wr_adr), w_t'(beat_q.size() / BEATS - 1));
            end
        end
    endtask

    // called right after the final beat was accepted
    task automatic finish_load(input int nrows);
        chk("ready_drop", w_t'(s_ready), w_t'(0));
        chk("busy_fin", w_t'(busy), w_t'(1));
        tick();
        chk("done_pulse", w_t'(done), w_t'(1));
        chk("busy_done", w_t'(busy), w_t'(1));
        chk("wr_en_off", w_t'(wr_en), w_t'(0));
        cks_at_done = checksum;
        chk("checksum", w_t'(checksum), w_t'(model_sum()));
        tick();
        chk("done_low", w_t'(done), w_t'(0));
        chk("busy_low", w_t'(busy), w_t'(0));
        chk("done_count", w_t'(done_cnt - done_base), w_t'(1));
        chk("wr_count", w_t'(got_adr.size() - got_base), w_t'(nrows));
        for (int r = 0; r < nrows && got_base + r < got_adr.size(); r++) begin
            chk("wr_adr", w_t'(got_adr[got_base + r]), w_t'(r));
            chk("wr_data", got_data[got_base + r], model_row(r));
        end
    endtask

    task automatic new_load();
        beat_q.delete();
        got_base  = got_adr.size();
        done_base = done_cnt;
    endtask

    initial begin
        w_t asc_row;

        // reset state
        rst_n = 1'b0; start = 1'b0; num_rows = '0; s_valid = 1'b0; s_data = '0;
        repeat (3) tick();
        chk("rst_ready", w_t'(s_ready), w_t'(0));
        chk("rst_wr_en", w_t'(wr_en), w_t'(0));
        chk("rst_busy", w_t'(busy), w_t'(0));
        chk("rst_done", w_t'(done), w_t'(0));
        chk("rst_adr", w_t'(wr_adr), w_t'(0));
        chk("rst_data", wr_data, w_t'(0));
        chk("rst_cks", w_t'(checksum), w_t'(0));
        rst_n = 1'b1;
        tick();

        // one row, ascending byte pattern, back-to-back
        new_load();
        pulse_start(1);
        chk("busy_after_start", w_t'(busy), w_t'(1));
        chk("ready_after_start", w_t'(s_ready), w_t'(1));
        send_beats(BEATS, 0, 1);
        finish_load(1);
        for (int i = 0; i < ROW_W / 8; i++) asc_row[i*8 +: 8] = 8'(i);
        if (got_data.size() > got_base) chk("asc_row", got_data[got_base], asc_row);
        else chk("asc_row_missing", w_t'(got_data.size()), w_t'(got_base + 1));

        // three rows with random valid gaps
        new_load();
        pulse_start(3);
        send_beats(3 * BEATS, 30, 0);
        finish_load(3);

        // zero rows: done next cycle, no writes, never busy
        new_load();
        pulse_start(0);
        chk("zero_done", w_t'(done), w_t'(1));
        chk("zero_busy", w_t'(busy), w_t'(0));
        tick();
        chk("zero_done_low", w_t'(done), w_t'(0));
        chk("zero_busy_low", w_t'(busy), w_t'(0));
        repeat (2) tick();
        chk("zero_no_write", w_t'(got_adr.size() - got_base), w_t'(0));
        chk("zero_cks", w_t'(checksum), w_t'(0));

        // start re-pulsed during row 1 of 4 is ignored
        new_load();
        pulse_start(4);
        send_beats(BEATS + 2, 20, 0);
        s_valid = 1'b0;
        pulse_start(2);
        chk("restart_ignored_busy", w_t'(busy), w_t'(1));
        chk("restart_ignored_ready", w_t'(s_ready), w_t'(1));
        send_beats(3 * BEATS - 2, 20, 0);
        finish_load(4);

        // reset during row 2, then a fresh two-row load
        new_load();
        pulse_start(3);
        send_beats(2 * BEATS + 5, 0, 0);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ready", w_t'(s_ready), w_t'(0));
        chk("mid_rst_wr_en", w_t'(wr_en), w_t'(0));
        chk("mid_rst_busy", w_t'(busy), w_t'(0));
        chk("mid_rst_done", w_t'(done), w_t'(0));
        chk("mid_rst_adr", w_t'(wr_adr), w_t'(0));
        chk("mid_rst_data", wr_data, w_t'(0));
        chk("mid_rst_cks", w_t'(checksum), w_t'(0));
        chk("pre_rst_writes", w_t'(got_adr.size() - got_base), w_t'(2));
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        new_load();
        pulse_start(2);
        send_beats(2 * BEATS, 25, 0);
        finish_load(2);

        // one row of all-ones bytes
        new_load();
        pulse_start(1);
        send_beats(BEATS, 0, 2);
        finish_load(1);
        chk("cks_all_ff", w_t'(cks_at_done), w_t'(CKS_EN ? 32'd16320 : 32'd0));
        repeat (2) tick();
        chk("cks_held", w_t'(checksum), w_t'(CKS_EN ? 32'd16320 : 32'd0));
        chk("idle_ready", w_t'(s_ready), w_t'(0));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
